seq_det_scheduler: RTL and testbench

Front-end controller for the 3-bit sequence detector datapath. It accepts parallel words over a valid/ready handshake and clears the detector before each word. It then serializes the word MSB-first onto the detector's serial input. It samples the detector's eight match flags, counts hits on one selected pattern per word, and returns the count and first-hit position over a second valid/ready handshake.

---
 rtl/seq_det_pkg.sv | 31 +++
 rtl/seq_det_scheduler_if.sv | 31 +++
 rtl/seq_det_serializer.sv | 51 +++++
 rtl/seq_det_scheduler.sv | 162 ++++++++++++++++
 tb/tb_seq_det_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the sequence-detector front end.
// det_y bit i flags pattern i: y000 is bit 0, y111 is bit 7.
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  localparam int YW = 8;

  localparam logic [2:0] PAT_000 = 3'd0;
  localparam logic [2:0] PAT_001 = 3'd1;
  localparam logic [2:0] PAT_010 = 3'd2;
  localparam logic [2:0] PAT_011 = 3'd3;
  localparam logic [2:0] PAT_100 = 3'd4;
  localparam logic [2:0] PAT_101 = 3'd5;
  localparam logic [2:0] PAT_110 = 3'd6;
  localparam logic [2:0] PAT_111 = 3'd7;

  function automatic logic pat_flag(
    input logic [YW-1:0] y,
    input logic [2:0]    p
  );
    return y[p];
  endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Word-in / result-out valid/ready bundle.
// master drives words and takes results; slave is the scheduler.
interface seq_det_scheduler_if #(
  parameter int W = 8
);
  localparam int CW = $clog2(W + 1);
  localparam int PW = $clog2(W);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [2:0]    in_pat;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          out_hit;
  logic [PW-1:0] out_first;

  modport master (
    output in_valid, in_data, in_pat, out_ready,
    input  in_ready, out_valid, out_count,
    input  out_hit, out_first
  );

  modport slave (
    input  in_valid, in_data, in_pat, out_ready,
    output in_ready, out_valid, out_count,
    output out_hit, out_first
  );

endinterface

// File: rtl/seq_det_serializer.sv
// MSB-first serializer feeding the detector's serial input.
// act/k mark which bit index det_x currently carries.
module seq_det_serializer #(
  parameter  int W  = 8,
  localparam int PW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [W-1:0]  data,
  input  logic          start,
  output logic          det_x,
  output logic          act,
  output logic [PW-1:0] k,
  output logic          last
);

  logic [W-1:0] sreg;

  assign last = act && (k == PW'(W - 1));

  // load the word, then present one bit per cycle on a registered det_x
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg  <= '0;
      k     <= '0;
      act   <= 1'b0;
      det_x <= 1'b0;
    end else if (load) begin
      sreg  <= data;
      k     <= '0;
      act   <= 1'b0;
      det_x <= 1'b0;
    end else if (start) begin
      det_x <= sreg[W-1];
      sreg  <= {sreg[W-2:0], 1'b0};
      act   <= 1'b1;
      k     <= '0;
    end else if (act) begin
      if (last) begin
        act   <= 1'b0;
        det_x <= 1'b0;
      end else begin
        k     <= k + 1'b1;
        det_x <= sreg[W-1];
        sreg  <= {sreg[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Front-end scheduler: clear, serialize, count hits, return result.
// Optional SEQ_DET_STATS_EN adds saturating word/hit statistics.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter  int W       = 8,
  parameter  int DET_LAT = 1,
  localparam int CW      = $clog2(W + 1),
  localparam int PW      = $clog2(W)
) (
  input  logic              clk,
  input  logic              reset,
  seq_det_scheduler_if.slave bus,
  output logic              det_x,
  output logic              det_clr,
  input  logic [YW-1:0]     det_y
`ifdef SEQ_DET_STATS_EN
  ,
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_hits
`endif
);

  localparam int DW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

  state_t        state_q, state_n;
  logic          rdy_q, clr_q, ov_q;
  logic          accept, start, act, last, samp;
  logic [PW-1:0] k;
  logic [DW-1:0] dcnt;
  logic [2:0]    pat_q;
  logic [CW-1:0] cnt;
  logic          hit;
  logic [PW-1:0] first;

  logic [DET_LAT-1:0] pv;
  logic [PW-1:0]      pk [DET_LAT];

  assign accept = (state_q == IDLE) && bus.in_valid && rdy_q;
  assign start  = (state_q == CLEAR);

  seq_det_serializer #(.W(W)) u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .data  (bus.in_data),
    .start (start),
    .det_x (det_x),
    .act   (act),
    .k     (k),
    .last  (last)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_n = CLEAR;
      CLEAR: state_n = SHIFT;
      SHIFT: if (last) state_n = DRAIN;
      DRAIN: if (dcnt == DW'(DET_LAT - 1)) state_n = DONE;
      DONE:  if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // handshake and clear outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q <= 1'b0;
      clr_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      rdy_q <= (state_n == IDLE);
      clr_q <= (state_n == CLEAR);
      ov_q  <= (state_n == DONE);
    end
  end

  // drain timer waits out the detector latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                dcnt <= '0;
    else if (state_q != DRAIN) dcnt <= '0;
    else                       dcnt <= dcnt + 1'b1;
  end

  // {valid, k} delayed to line up with det_y
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      for (int i = 0; i < DET_LAT; i++) pk[i] <= '0;
    end else begin
      pv[0] <= act;
      pk[0] <= k;
      for (int i = 1; i < DET_LAT; i++) begin
        pv[i] <= pv[i-1];
        pk[i] <= pk[i-1];
      end
    end
  end

  // first two bits after clear lack a full 3-bit history
  assign samp = pv[DET_LAT-1]
             && (pk[DET_LAT-1] >= PW'(2))
             && pat_flag(det_y, pat_q);

  // per-word match count and first-hit position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= '0;
      cnt   <= '0;
      hit   <= 1'b0;
      first <= '0;
    end else if (accept) begin
      pat_q <= bus.in_pat;
      cnt   <= '0;
      hit   <= 1'b0;
      first <= '0;
    end else if (samp) begin
      cnt <= cnt + 1'b1;
      if (!hit) begin
        hit   <= 1'b1;
        first <= pk[DET_LAT-1];
      end
    end
  end

  assign det_clr       = clr_q;
  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = ov_q;
  assign bus.out_count = cnt;
  assign bus.out_hit   = hit;
  assign bus.out_first = first;

`ifdef SEQ_DET_STATS_EN
  logic [15:0] words_q, hits_q;
  logic [16:0] hsum;

  assign hsum = {1'b0, hits_q} + 17'(cnt);

  // saturating totals, bumped on each delivered result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_q <= '0;
      hits_q  <= '0;
    end else if ((state_q == DONE) && bus.out_ready) begin
      if (words_q != 16'hFFFF) words_q <= words_q + 1'b1;
      hits_q <= hsum[16] ? 16'hFFFF : hsum[15:0];
    end
  end

  assign stat_words = words_q;
  assign stat_hits  = hits_q;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler with a 3-bit detector model.
// Table vectors, random words vs a window-count model, corner sequences.
module tb_seq_det_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       det_x, det_clr;
  logic [7:0] det_y;
  logic [2:0] hist;
`ifdef SEQ_DET_STATS_EN
  logic [15:0] stat_words, stat_hits;
`endif

  int checks = 0;
  int errors = 0;

  seq_det_scheduler_if #(.W(8)) bus ();

  seq_det_scheduler #(.W(8), .DET_LAT(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .det_x   (det_x),
    .det_clr (det_clr),
    .det_y   (det_y)
`ifdef SEQ_DET_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_hits  (stat_hits)
`endif
  );

  always #5 clk = ~clk;

  // detector: 3-bit history, newest bit at LSB, one-hot flags one cycle later
  always @(posedge clk or negedge reset) begin
    if (!reset)       hist <= 3'd0;
    else if (det_clr) hist <= 3'd0;
    else              hist <= {hist[1:0], det_x};
  end
  assign det_y = 8'h01 << hist;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // expected result from sliding 3-bit windows over the word
  task automatic model(input logic [7:0] d, input logic [2:0] p,
                       output int c, output int h, output int f);
    int b [8];
    for (int i = 0; i < 8; i++) b[i] = int'(d[7-i]);
    c = 0; f = 0;
    for (int kk = 2; kk < 8; kk++) begin
      if (b[kk-2] * 4 + b[kk-1] * 2 + b[kk] == int'(p)) begin
        if (c == 0) f = kk;
        c++;
      end
    end
    h = (c != 0) ? 1 : 0;
  endtask

  task automatic run_word(input logic [7:0] d, input logic [2:0] p,
                          input int hold, output int lat,
                          output logic [7:0] xs, output int clrs,
                          output int rc, output int rh, output int rf);
    int n;
    logic [12:0] snap;
    int stab;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_pat   = p;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", n, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_pat   = 3'($urandom);
    lat = 0; xs = '0; clrs = 0;
    while (!bus.out_valid && lat < 100) begin
      if (det_clr) clrs++;
      if (lat >= 1 && lat <= 8) xs = {xs[6:0], det_x};
      @(posedge clk); #1;
      lat++;
    end
    rc = int'(bus.out_count);
    rh = int'(bus.out_hit);
    rf = int'(bus.out_first);
    snap = {bus.out_valid, bus.in_ready, bus.out_count,
            bus.out_hit, bus.out_first, det_clr, det_x};
    stab = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if ({bus.out_valid, bus.in_ready, bus.out_count, bus.out_hit,
           bus.out_first, det_clr, det_x} != snap) stab = 0;
    end
    if (hold > 0) chk("hold_stable", stab, 1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_valid", int'(bus.out_valid), 0);
    chk("release_ready", int'(bus.in_ready), 1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] p;
    int         c;
    int         h;
    int         f;
  } vec_t;

  vec_t tbl [7];

  task automatic word_check(input string tag, input logic [7:0] d,
                            input logic [2:0] p, input int ec,
                            input int eh, input int ef, input int hold);
    int lat, clrs, rc, rh, rf;
    logic [7:0] xs;
    run_word(d, p, hold, lat, xs, clrs, rc, rh, rf);
    chk({tag, "_count"}, rc, ec);
    chk({tag, "_hit"}, rh, eh);
    chk({tag, "_first"}, rf, ef);
    chk({tag, "_latency"}, lat, 10);
    chk({tag, "_detx"}, int'(xs), int'(d));
    chk({tag, "_clr"}, clrs, 1);
  endtask

  initial begin
    int c, h, f;
    logic [7:0] d;
    logic [2:0] p;

    tbl[0] = '{8'hAD, 3'd5, 3, 1, 2};
    tbl[1] = '{8'hFF, 3'd7, 6, 1, 2};
    tbl[2] = '{8'h00, 3'd7, 0, 0, 0};
    tbl[3] = '{8'h00, 3'd0, 6, 1, 2};
    tbl[4] = '{8'hC0, 3'd0, 4, 1, 4};
    tbl[5] = '{8'h01, 3'd1, 1, 1, 7};
    tbl[6] = '{8'hC0, 3'd6, 1, 1, 2};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_pat    = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", int'({bus.in_ready, bus.out_valid, det_x, det_clr}), 0);
    chk("rst_fields", int'({bus.out_count, bus.out_hit, bus.out_first}), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);

    foreach (tbl[i])
      word_check("vec", tbl[i].d, tbl[i].p, tbl[i].c, tbl[i].h, tbl[i].f, 0);

    word_check("backpressure", 8'hAD, 3'd5, 3, 1, 2, 10);
    word_check("after_bp", 8'hFF, 3'd7, 6, 1, 2, 0);

    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      p = 3'($urandom);
      model(d, p, c, h, f);
      word_check("rand", d, p, c, h, f, $urandom_range(0, 2));
    end

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAD;
    bus.in_pat   = 3'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_ctl", int'({bus.in_ready, bus.out_valid, det_x, det_clr}), 0);
    chk("midrst_fields", int'({bus.out_count, bus.out_hit, bus.out_first}), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", int'(bus.in_ready), 1);
    word_check("midrst_word", 8'hFF, 3'd7, 6, 1, 2, 0);

`ifdef SEQ_DET_STATS_EN
    word_check("stat_w2", 8'hAD, 3'd5, 3, 1, 2, 0);
    word_check("stat_w3", 8'h00, 3'd7, 0, 0, 0, 0);
    chk("stat_words", int'(stat_words), 3);
    chk("stat_hits", int'(stat_hits), 9);
    @(negedge clk);
    force dut.hits_q = 16'hFFFE;
    #1;
    release dut.hits_q;
    word_check("stat_sat", 8'hAD, 3'd5, 3, 1, 2, 0);
    chk("stat_hits_sat", int'(stat_hits), 65535);
    chk("stat_words4", int'(stat_words), 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
